crc_sched: RTL and testbench

CRC_SCHED -- requirements
Module: crc_sched

---
 rtl/crc_sched.sv | 147 ++++++++++++++
 tb/tb_crc_sched.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crc_sched.sv
// crc_sched: round-robin arbiter feeding a shared byte-serial CRC engine.
// One frame at a time; result held until the consumer takes it.
module crc_sched #(
  parameter int          NUM_REQ = 4,
  parameter int          WIDTH   = 32,
  parameter logic [31:0] POLY    = 32'h04C11DB7,
  parameter logic [31:0] INIT    = 32'hFFFFFFFF,
  parameter bit          REFIN   = 1'b1,
  parameter bit          REFOUT  = 1'b1,
  parameter logic [31:0] XOROUT  = 32'hFFFFFFFF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [8*NUM_REQ-1:0]       req_data,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_crc,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic                       busy
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam logic [WIDTH-1:0] P   = POLY[WIDTH-1:0];
  localparam logic [WIDTH-1:0] INI = INIT[WIDTH-1:0];
  localparam logic [WIDTH-1:0] XO  = XOROUT[WIDTH-1:0];

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   pick;
  logic [IDW-1:0]   ptr_nxt;
  logic [WIDTH-1:0] crc;
  logic [WIDTH-1:0] crc_nxt;
  logic             hit;
  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;

  function automatic logic [WIDTH-1:0] step(
    input logic [WIDTH-1:0] c,
    input logic [7:0]       d
  );
    logic [WIDTH-1:0] r;
    logic [7:0]       b;
    logic             fb;
    r = c;
    for (int j = 0; j < 8; j++)
      b[j] = REFIN ? d[7-j] : d[j];
    for (int j = 7; j >= 0; j--) begin
      fb = r[WIDTH-1] ^ b[j];
      r  = {r[WIDTH-2:0], 1'b0};
      if (fb) r = r ^ P;
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] fin(
    input logic [WIDTH-1:0] c
  );
    logic [WIDTH-1:0] r;
    for (int j = 0; j < WIDTH; j++)
      r[j] = REFOUT ? c[WIDTH-1-j] : c[j];
    return r ^ XO;
  endfunction

  // first pass: lowest index >= ptr; second pass covers the wrap
  always_comb begin
    pick = '0;
    hit  = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_valid[i] && IDW'(i) >= ptr) begin
        hit  = 1'b1;
        pick = IDW'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!hit && req_valid[i]) begin
        hit  = 1'b1;
        pick = IDW'(i);
      end
    end
  end

  always_comb begin
    g_valid   = 1'b0;
    g_last    = 1'b0;
    g_data    = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant == IDW'(i)) begin
        g_valid      = req_valid[i];
        g_last       = req_last[i];
        g_data       = req_data[8*i +: 8];
        req_ready[i] = (state == RUN);
      end
    end
  end

  assign crc_nxt   = step(crc, g_data);
  assign ptr_nxt   = (grant == IDW'(NUM_REQ-1)) ? '0 : grant + IDW'(1);
  assign res_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      grant   <= '0;
      crc     <= INI;
      res_crc <= '0;
      res_id  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            grant <= pick;
            crc   <= INI;
            state <= RUN;
          end
        end
        RUN: begin
          if (g_valid) begin
            crc <= crc_nxt;
            if (g_last) begin
              res_crc <= fin(crc_nxt);
              res_id  <= grant;
              state   <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            ptr   <= ptr_nxt;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crc_sched.sv
// tb_crc_sched: scoreboard bench for crc_sched with a CRC-32 reference model.
// Directed frames plus randomized multi-requester traffic with stalls.
module tb_crc_sched;

  localparam int N = 4;
  localparam int K = 5;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           res_valid;
  logic           res_ready;
  logic [31:0]    res_crc;
  logic [1:0]     res_id;
  logic           busy;

  logic       vld[N];
  logic       lst[N];
  logic [7:0] dat[N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_cyc = 0;
  bit rnd_on = 1'b0;

  logic [7:0]  frm[N][$];
  int          exp_id[$];
  logic [31:0] exp_crc[N][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = vld[i];
      req_last[i]        = lst[i];
      req_data[8*i +: 8] = dat[i];
    end
  end

  crc_sched dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_crc   (res_crc),
    .res_id    (res_id),
    .busy      (busy)
  );

  // standard reflected CRC-32, LSB-first with the reversed polynomial
  function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      c = c ^ {24'd0, q[k]};
      for (int b = 0; b < 8; b++)
        c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    logic        pv, pr;
    logic [31:0] pc;
    logic [1:0]  pid;
    int          e;
    pv = 1'b0; pr = 1'b1; pc = '0; pid = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0;
        continue;
      end
      if (req_ready != '0)
        chk("ready_onehot", $countones(req_ready), 1);
      if (res_valid)
        chk("ready_in_done", {28'd0, req_ready}, 0);
      if (res_valid && pv && !pr) begin
        chk("stall_crc", res_crc, pc);
        chk("stall_id", {30'd0, res_id}, {30'd0, pid});
      end
      if (res_valid && !pv) rise_cyc = cyc;
      if (res_valid && res_ready) begin
        if (exp_id.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result: got id %0d expected none", res_id);
        end else begin
          e = exp_id.pop_front();
          chk("res_id", {30'd0, res_id}, e);
          if (exp_crc[e].size() == 0) begin
            checks++; errors++;
            $display("FAIL no_expected_crc: got %h expected none", res_crc);
          end else begin
            chk("res_crc", res_crc, exp_crc[e].pop_front());
          end
        end
      end
      pv = res_valid; pr = res_ready; pc = res_crc; pid = res_id;
    end
  endtask

  task automatic drive(input int r, input bit nolast, input int gapmax);
    int n;
    bit acc;
    n = frm[r].size();
    for (int i = 0; i < n; i++) begin
      dat[r] = frm[r][i];
      lst[r] = (i == n - 1) && !nolast;
      vld[r] = 1'b1;
      acc = 1'b0;
      for (int t = 0; t < 300 && !acc; t++) begin
        @(negedge clk);
        acc = req_ready[r];
        @(posedge clk); #1;
      end
      if (!acc) begin
        checks++; errors++;
        $display("FAIL accept_timeout req %0d: got no ready expected ready", r);
        vld[r] = 1'b0; lst[r] = 1'b0;
        return;
      end
      vld[r] = 1'b0;
      lst[r] = 1'b0;
      if (i < n - 1 && gapmax > 0)
        repeat ($urandom_range(0, gapmax)) begin
          @(posedge clk); #1;
        end
    end
  endtask

  task automatic rand_frame(input int r, input int maxlen);
    int len;
    frm[r].delete();
    len = $urandom_range(1, maxlen);
    for (int i = 0; i < len; i++)
      frm[r].push_back(8'($urandom_range(0, 255)));
    exp_crc[r].push_back(ref_crc(frm[r]));
  endtask

  task automatic rnd_driver(input int r);
    for (int f = 0; f < K; f++) begin
      rand_frame(r, 10);
      drive(r, 1'b0, 3);
    end
  endtask

  task automatic wait_drain(input int bound);
    int t;
    t = 0;
    while (exp_id.size() != 0 && t < bound) begin
      @(posedge clk);
      t++;
    end
    if (exp_id.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_id.size());
      exp_id.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) vld[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_str(input int r, input string s);
    frm[r].delete();
    for (int i = 0; i < s.len(); i++) frm[r].push_back(s[i]);
  endtask

  initial begin
    int c0;
    string digits;
    digits = "123456789";
    for (int i = 0; i < N; i++) begin
      vld[i] = 1'b0; lst[i] = 1'b0; dat[i] = '0;
    end
    res_ready = 1'b1;
    rst_n = 1'b0;
    fork monitor(); join_none

    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", {28'd0, req_ready}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_crc", res_crc, 0);
    chk("rst_res_id", {30'd0, res_id}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // check value from requester 0, with latency
    load_str(0, digits);
    exp_id.push_back(0);
    exp_crc[0].push_back(32'hCBF43926);
    c0 = cyc;
    fork drive(0, 1'b0, 0); join_none
    wait_drain(200);
    chk("latency", rise_cyc - c0, 1 + 9);

    // single zero byte from requester 2
    frm[2].delete();
    frm[2].push_back(8'h00);
    exp_id.push_back(2);
    exp_crc[2].push_back(32'hD202EF8D);
    fork drive(2, 1'b0, 0); join_none
    wait_drain(200);

    // simultaneous requests right after reset
    do_reset();
    rand_frame(0, 6);
    rand_frame(1, 6);
    exp_id.push_back(0);
    exp_id.push_back(1);
    fork
      drive(0, 1'b0, 2);
      drive(1, 1'b0, 2);
    join_none
    wait_drain(300);

    // frame from 2, stall in DONE while 0 and 3 wait, then 3 before 0
    rand_frame(2, 4);
    exp_id.push_back(2);
    res_ready = 1'b0;
    fork drive(2, 1'b0, 0); join_none
    for (int t = 0; t < 100 && !res_valid; t++) begin
      @(posedge clk); #1;
    end
    chk("stall_entry", {31'd0, res_valid}, 1);
    rand_frame(0, 5);
    rand_frame(3, 5);
    exp_id.push_back(3);
    exp_id.push_back(0);
    fork
      drive(0, 1'b0, 1);
      drive(3, 1'b0, 1);
    join_none
    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("stall_busy", {31'd0, busy}, 1);
    chk("stall_ready", {28'd0, req_ready}, 0);
    chk("stall_hold_id", {30'd0, res_id}, 2);
    res_ready = 1'b1;
    wait_drain(400);

    // abort a partial frame with reset, then resend
    load_str(0, "1234");
    drive(0, 1'b1, 0);
    chk("abort_busy", {31'd0, busy}, 1);
    do_reset();
    load_str(0, digits);
    exp_id.push_back(0);
    exp_crc[0].push_back(32'hCBF43926);
    fork drive(0, 1'b0, 0); join_none
    wait_drain(200);

    // all requesters saturated: strict rotation from ptr=0
    do_reset();
    for (int f = 0; f < K; f++)
      for (int r = 0; r < N; r++) exp_id.push_back(r);
    rnd_on = 1'b1;
    fork
      while (rnd_on) begin
        @(posedge clk); #1;
        res_ready = ($urandom_range(0, 9) < 7);
      end
    join_none
    for (int r = 0; r < N; r++) begin
      automatic int rr = r;
      fork rnd_driver(rr); join_none
    end
    wait_drain(6000);
    rnd_on = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
